// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the fetch/data memory port arbiter.
package mem_arb_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  localparam int RUN_W      = 4;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/mem_arb_select.sv
// Winner select between fetch and data requesters, with a bounded run of
// back-to-back data grants so a waiting fetch cannot starve.
module mem_arb_select
  import mem_arb_pkg::*;
#(
  parameter int MAX_DATA_RUN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic grant_en,
  input  logic i_req,
  input  logic d_req,
  output logic i_gnt,
  output logic d_gnt
);

  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DATA_RUN);

  logic [RUN_W-1:0] run_q;
  logic [RUN_W-1:0] run_d;
  logic             fetch_turn;

  always_comb begin
    fetch_turn = i_req && (!d_req || (run_q == RUN_MAX));
    i_gnt      = grant_en && fetch_turn;
    d_gnt      = grant_en && d_req && !fetch_turn;
    run_d      = run_q;
    if (i_gnt) begin
      run_d = '0;
    end else if (d_gnt && (run_q != RUN_MAX)) begin
      run_d = run_q + RUN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= '0;
    end else begin
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-ported memory between instruction fetch and
// load/store; each transfer is grant, MEM_LAT access cycles, then one response.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = MEM_ADDR_W,
  parameter int DATA_W       = MEM_DATA_W,
  parameter int MEM_LAT      = 1,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic [DATA_W/8-1:0] d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_read,
  output logic [DATA_W/8-1:0] mem_write,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_in,
  input  logic [DATA_W-1:0]   mem_out
);

  localparam int         STRB_W   = DATA_W / 8;
  localparam logic [2:0] CNT_LAST = 3'(MEM_LAT - 1);

  arb_state_e          state_q, state_d;
  arb_owner_e          owner_q, owner_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [STRB_W-1:0]   we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                is_store;

  mem_arb_select #(
    .MAX_DATA_RUN(MAX_DATA_RUN)
  ) u_select (
    .clk      (clk),
    .rst      (rst),
    .grant_en ((state_q == ARB_IDLE) && !rst),
    .i_req    (i_req),
    .d_req    (d_req),
    .i_gnt    (i_gnt),
    .d_gnt    (d_gnt)
  );

  assign is_store = (owner_q == OWN_DATA) && (we_q != '0);

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      ARB_IDLE: begin
        if (i_gnt || d_gnt) begin
          owner_d = d_gnt ? OWN_DATA : OWN_FETCH;
          addr_d  = d_gnt ? d_addr : i_addr;
          we_d    = d_gnt ? d_we : '0;
          // Store data only comes from the data port; a fetch leaves it alone.
          if (d_gnt) begin
            wdata_d = d_wdata;
          end
          cnt_d   = '0;
          state_d = ARB_ACCESS;
        end
      end
      ARB_ACCESS: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ARB_RESP;
          if (!is_store) begin
            if (owner_q == OWN_FETCH) begin
              i_rdata_d = mem_out;
            end else begin
              d_rdata_d = mem_out;
            end
          end
        end
      end
      ARB_RESP: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      owner_q   <= OWN_FETCH;
      cnt_q     <= '0;
      addr_q    <= '0;
      we_q      <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  always_comb begin
    mem_read  = (state_q == ARB_ACCESS) && !is_store;
    mem_write = ((state_q == ARB_ACCESS) && is_store) ? we_q : '0;
    mem_addr  = addr_q;
    mem_in    = wdata_q;
    i_rvalid  = (state_q == ARB_RESP) && (owner_q == OWN_FETCH);
    d_rvalid  = (state_q == ARB_RESP) && (owner_q == OWN_DATA);
    i_rdata   = i_rdata_q;
    d_rdata   = d_rdata_q;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported, fixed-latency memory between the CPU instruction-fetch requester and the load/store data requester, so the core can run from a unified memory.
- Arbitrates requests and latches the winning request.
- Sequences the memory port for a programmable number of cycles.
- Returns read data or write completion to the owner.
- Sits between the CPU core and the unified memory model.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (byte strobes = DATA_W/8)
MEM_LAT, 1, memory access cycles per transfer; legal 1..4
MAX_DATA_RUN, 4, consecutive data grants allowed while fetch waits; legal 1..15

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset, synchronous, active-high
i_req  in  1  fetch request; held with i_addr stable until i_gnt
i_addr  in  ADDR_W  fetch address
i_gnt  out  1  one-cycle pulse: fetch request accepted
i_rvalid  out  1  one-cycle pulse: i_rdata valid
i_rdata  out  DATA_W  fetched word; holds until next fetch response
d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_gnt
d_we  in  DATA_W/8  byte write strobes; all-zero = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_gnt  out  1  one-cycle pulse: data request accepted
d_rvalid  out  1  one-cycle pulse: load data valid or store complete
d_rdata  out  DATA_W  load word; holds until next data load response
mem_read  out  1  memory read enable
mem_write  out  DATA_W/8  memory byte write enables
mem_addr  out  ADDR_W  memory address
mem_in  out  DATA_W  write data to memory
mem_out  in  DATA_W  read data from memory

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any request is present, assert the winner's gnt combinationally in that cycle.
  - At the clock edge, latch owner, address, strobes and wdata; go to ACCESS with cnt=0.
  - With no request present, stay in IDLE.
- Arbitration: data wins over fetch, except when i_req=1 and run==MAX_DATA_RUN; then fetch wins.
  - run increments on a data grant, saturating at MAX_DATA_RUN.
  - run clears to 0 on a fetch grant.
- ACCESS lasts exactly MEM_LAT cycles.
  - Drive mem_addr = latched address.
  - Load/fetch: mem_read=1, mem_write=0.
  - Store: mem_read=0, mem_write=latched strobes, mem_in=latched wdata.
  - cnt increments each cycle.
  - On the cycle where cnt==MEM_LAT-1: capture mem_out into the owner's rdata register (loads/fetches only), then go to RESP.
- RESP: the owner's rvalid=1 for one cycle; always go to IDLE next.
- Throughput: one transfer per MEM_LAT+2 cycles.
- Outside ACCESS: mem_read=0, mem_write=0; mem_addr/mem_in hold their last latched values.
- i_gnt and d_gnt are never both 1. Only the current owner's rvalid can pulse.
- A store never modifies d_rdata. A fetch never modifies d_rdata, and vice versa.
- Request dropped before gnt: treated as withdrawn, no side effect. After gnt, req may drop or present the next request.
- Reset (any state, including mid-ACCESS):
  - Next cycle: state=IDLE, cnt=0, run=0, latched regs=0, i_rdata=d_rdata=0.
  - All outputs 0.
  - The aborted transfer produces no rvalid.
  - gnt is suppressed while rst=1.

Decomposition:
- Package mem_arb_pkg:
  - State enum ARB_IDLE/ARB_ACCESS/ARB_RESP.
  - Owner enum OWN_FETCH/OWN_DATA.
  - Width constants ADDR_W/DATA_W.
- Sub-module mem_arb_select: combinational winner select plus registered run counter and saturation.
- Top: FSM, latency counter, request latch, response registers.

Test Plan:
- Reset: rst=1 for 2 cycles, with i_req=d_req=1 -> all outputs 0, no gnt; first gnt in the cycle after rst falls.
- Fetch, MEM_LAT=1, i_addr=0x10, memory[0x10]=0x00500093:
  - cycle0: i_gnt=1.
  - cycle1: mem_read=1, mem_addr=0x10.
  - cycle2: i_rvalid=1, i_rdata=0x00500093.
- Simultaneous i_req and d_req (d_we=0, d_addr=0x100) at cycle0, MEM_LAT=1 -> d_gnt cycle0, d_rvalid cycle2, i_gnt cycle3, i_rvalid cycle5.
- Starvation, MAX_DATA_RUN=4, d_req and i_req held high -> grant order D,D,D,D,I,D...; run=0 after the I grant.
- Store: d_we=4'b0011, d_addr=0x22, d_wdata=0xAABBCCDD, MEM_LAT=2, d_rdata preloaded 0x12345678 -> mem_write=0011 and mem_in=0xAABBCCDD for exactly 2 cycles, mem_read=0, d_rvalid pulse, d_rdata stays 0x12345678.
- MEM_LAT=3, rst asserted in the 2nd ACCESS cycle of a load -> mem_read=0 next cycle, no d_rvalid, d_rdata=0; next request is served normally.
